// File: rtl/avalon_id_regbank_if.sv
// Avalon-MM slave bus bundle for avalon_id_regbank.
// AVALON_REGBANK_BYTEEN_EN adds byteenable to the bundle.
interface avalon_id_regbank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
`ifdef AVALON_REGBANK_BYTEEN_EN
  logic [DATA_W/8-1:0] byteenable;

  modport master (
    output address, write, writedata, read, byteenable,
    input  readdata, waitrequest
  );
  modport slave (
    input  address, write, writedata, read, byteenable,
    output readdata, waitrequest
  );
`else
  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );
  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
`endif
endinterface

// File: rtl/avalon_id_regbank.sv
// Avalon-MM register bank: ID switches, build ID, sticky switch-change status,
// read counter and N_RW RW registers. AVALON_REGBANK_BYTEEN_EN enables byte-lane writes.
module avalon_id_regbank #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       ADDR_SHIFT = 8,
  parameter int unsigned       N_RW       = 12,
  parameter int unsigned       SW_W       = 4,
  parameter logic [DATA_W-1:0] BUILD_ID   = DATA_W'(32'h1D5C0001),
  parameter logic [DATA_W-1:0] BAD_ADDR   = DATA_W'(32'hDEADBEEF)
) (
  input  logic                     clock,
  input  logic                     reset,
  avalon_id_regbank_if.slave       avalon_slave,
  input  logic [SW_W-1:0]          sw,
  output logic [N_RW*DATA_W-1:0]   reg_out,
  output logic                     sw_changed
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [SW_W-1:0]   sw_prev;
  logic [DATA_W-1:0] rw_regs [N_RW];
  logic [DATA_W-1:0] rd_count;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] wr_mask;
  logic [31:0]       idx;
  logic              wr_en;
  logic              sts_be;
  logic              sts_clr;

  assign idx   = 32'(avalon_slave.address >> ADDR_SHIFT);
  // a read always wins over a simultaneous write
  assign wr_en = avalon_slave.write && !avalon_slave.read;

  assign avalon_slave.waitrequest = avalon_slave.read && (state == IDLE) && !reset;

`ifdef AVALON_REGBANK_BYTEEN_EN
  localparam int unsigned BE_W = DATA_W / 8;
  for (genvar b = 0; b < BE_W; b++) begin : g_be
    assign wr_mask[b*8 +: 8] = {8{avalon_slave.byteenable[b]}};
  end
  assign sts_be = avalon_slave.byteenable[0];
`else
  assign wr_mask = '1;
  assign sts_be  = 1'b1;
`endif

  assign sts_clr = wr_en && (idx == 32'd2) && avalon_slave.writedata[0] && sts_be;

  // read data source for the current index
  always_comb begin
    rd_mux = BAD_ADDR;
    case (idx)
      32'd0:   rd_mux = DATA_W'(sw_sync);
      32'd1:   rd_mux = BUILD_ID;
      32'd2:   rd_mux = DATA_W'(sw_changed);
      32'd3:   rd_mux = rd_count;
      default: begin
        for (int k = 0; k < int'(N_RW); k++) begin
          if (idx == 32'(k + 4)) rd_mux = rw_regs[k];
        end
      end
    endcase
  end

  // read FSM: latch in IDLE, master samples in RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      avalon_slave.readdata <= '0;
      rd_count              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (avalon_slave.read) begin
            avalon_slave.readdata <= rd_mux;
            state                 <= RESP;
          end
        end
        RESP: begin
          if (avalon_slave.read) rd_count <= rd_count + DATA_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // switch synchroniser, change detect and sticky status (set beats clear)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      sw_prev    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_meta    <= sw;
      sw_sync    <= sw_meta;
      sw_prev    <= sw_sync;
      sw_changed <= (sw_sync != sw_prev) || (sw_changed && !sts_clr);
    end
  end

  // RW registers with byte-lane merge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(N_RW); k++) rw_regs[k] <= '0;
    end else begin
      for (int k = 0; k < int'(N_RW); k++) begin
        if (wr_en && (idx == 32'(k + 4)))
          rw_regs[k] <= (rw_regs[k] & ~wr_mask) | (avalon_slave.writedata & wr_mask);
      end
    end
  end

  for (genvar k = 0; k < N_RW; k++) begin : g_out
    assign reg_out[k*DATA_W +: DATA_W] = rw_regs[k];
  end

endmodule

// File: tb/tb_avalon_id_regbank.sv
// Directed bench for avalon_id_regbank; honours AVALON_REGBANK_BYTEEN_EN when defined.
module tb_avalon_id_regbank;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned N_RW   = 12;
  localparam int unsigned SW_W   = 4;

  logic                   clock;
  logic                   reset;
  logic [SW_W-1:0]        sw;
  logic [N_RW*DATA_W-1:0] reg_out;
  logic [N_RW*DATA_W-1:0] exp_regs;
  logic                   sw_changed;

  int total;
  int bad;

  avalon_id_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avs ();

  avalon_id_regbank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_SHIFT(8), .N_RW(N_RW), .SW_W(SW_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .avalon_slave (avs),
    .sw           (sw),
    .reg_out      (reg_out),
    .sw_changed   (sw_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int idx);
    avs.address = 16'(idx << 8);
  endtask

  // called at a negedge; returns at a negedge with write low
  task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] be);
    set_addr(idx);
    avs.writedata = data;
`ifdef AVALON_REGBANK_BYTEEN_EN
    avs.byteenable = be;
`else
    if (be != 4'hF) $display("note: byteenable %h ignored in full-word build", be);
`endif
    avs.write = 1'b1;
    @(negedge clock);
    avs.write = 1'b0;
`ifdef AVALON_REGBANK_BYTEEN_EN
    avs.byteenable = 4'hF;
`endif
  endtask

  // 2-cycle read: stall in IDLE, data visible in RESP
  task automatic rd(input int idx, input logic [31:0] exp, input string tag);
    set_addr(idx);
    avs.read = 1'b1;
    #1;
    chk({tag, "_wait"}, 64'(avs.waitrequest), 64'd1);
    @(negedge clock);
    chk({tag, "_nowait"}, 64'(avs.waitrequest), 64'd0);
    chk(tag, 64'(avs.readdata), 64'(exp));
    @(negedge clock);
    avs.read = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sw    = 4'hA;
    avs.address   = '0;
    avs.write     = 1'b0;
    avs.writedata = '0;
    avs.read      = 1'b1;
`ifdef AVALON_REGBANK_BYTEEN_EN
    avs.byteenable = 4'hF;
`endif

    // T1: reset state, then switch readout and read counter
    repeat (2) @(negedge clock);
    #1;
    chk("rst_wait", 64'(avs.waitrequest), 64'd0);
    chk("rst_rdata", 64'(avs.readdata), 64'd0);
    chk("rst_swchg", 64'(sw_changed), 64'd0);
    chk("rst_regs", 64'(reg_out == '0), 64'd1);
    @(negedge clock);
    avs.read = 1'b0;
    reset    = 1'b0;
    repeat (3) @(negedge clock);
    rd(0, 32'h0000000A, "t1_sw");
    rd(3, 32'd1, "t1_cnt");

    // T2: RW register write/readback
    wr(4, 32'h12345678, 4'hF);
    rd(4, 32'h12345678, "t2_rd4");
    chk("t2_slice0", 64'(reg_out[31:0]), 64'h12345678);
    chk("t2_others", 64'(reg_out[N_RW*DATA_W-1:32] == '0), 64'd1);

    // T3: unmapped indices and read/write collision
    exp_regs = '0;
    exp_regs[31:0] = 32'h12345678;
    rd(8'hFF, 32'hDEADBEEF, "t3_bad");
    wr(8'hFF, 32'hCAFEF00D, 4'hF);
    chk("t3_wr_ff", 64'(reg_out === exp_regs), 64'd1);
    wr(16, 32'h0BADF00D, 4'hF);
    chk("t3_wr_16", 64'(reg_out === exp_regs), 64'd1);
    rd(15, 32'h0, "t3_last");
    rd(16, 32'hDEADBEEF, "t3_past");
    avs.writedata = 32'h55AA55AA;
    avs.write     = 1'b1;
    rd(5, 32'h0, "t3_rw_coll");
    avs.write     = 1'b0;
    chk("t3_coll_drop", 64'(reg_out === exp_regs), 64'd1);

    // T4: sticky status with W1C and set-beats-clear
    chk("t4_set_rst", 64'(sw_changed), 64'd1);
    wr(2, 32'hFFFFFFFE, 4'hF);
    chk("t4_w0_keep", 64'(sw_changed), 64'd1);
    wr(2, 32'h1, 4'hF);
    chk("t4_clr", 64'(sw_changed), 64'd0);
    rd(2, 32'h0, "t4_rd_clr");
    sw = 4'h0;
    repeat (5) @(negedge clock);
    wr(2, 32'h1, 4'hF);
    chk("t4_clr0", 64'(sw_changed), 64'd0);
    sw = 4'h3;
    repeat (4) @(negedge clock);
    chk("t4_set3", 64'(sw_changed), 64'd1);
    wr(2, 32'h1, 4'hF);
    chk("t4_clr3", 64'(sw_changed), 64'd0);
    sw = 4'h0;
    repeat (2) @(negedge clock);
    wr(2, 32'h1, 4'hF);
    chk("t4_set_wins", 64'(sw_changed), 64'd1);
    @(negedge clock);
    chk("t4_set_hold", 64'(sw_changed), 64'd1);
    rd(2, 32'h1, "t4_rd_set");
    wr(2, 32'h1, 4'hF);
    chk("t4_clr_end", 64'(sw_changed), 64'd0);

    // T5: back-to-back reads, aborted read, then reset mid-read
    rd(1, 32'h1D5C0001, "t5_b2b0");
    rd(1, 32'h1D5C0001, "t5_b2b1");
    rd(1, 32'h1D5C0001, "t5_b2b2");
    rd(3, 32'd12, "t5_cnt");
    set_addr(1);
    avs.read = 1'b1;
    @(negedge clock);
    avs.read = 1'b0;
    @(negedge clock);
    rd(3, 32'd13, "t5_abort_cnt");
    set_addr(1);
    avs.read = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_wait", 64'(avs.waitrequest), 64'd0);
    chk("t5_rst_rdata", 64'(avs.readdata), 64'd0);
    chk("t5_rst_swchg", 64'(sw_changed), 64'd0);
    chk("t5_rst_regs", 64'(reg_out == '0), 64'd1);
    @(negedge clock);
    chk("t5_rst_wait2", 64'(avs.waitrequest), 64'd0);
    avs.read = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    rd(3, 32'd0, "t5_cnt_rst");
    rd(4, 32'd0, "t5_reg_rst");

`ifdef AVALON_REGBANK_BYTEEN_EN
    // T6: byte-lane writes and byte-0 gated W1C
    wr(5, 32'hFFFFFFFF, 4'hF);
    wr(5, 32'h00000000, 4'b0101);
    chk("t6_be", 64'(reg_out[63:32]), 64'hFF00FF00);
    sw = 4'h5;
    repeat (5) @(negedge clock);
    chk("t6_sts_set", 64'(sw_changed), 64'd1);
    wr(2, 32'h1, 4'b1110);
    chk("t6_w1c_nobe", 64'(sw_changed), 64'd1);
    wr(2, 32'h1, 4'b0001);
    chk("t6_w1c_be0", 64'(sw_changed), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
